// File: rtl/pe_cmd_sched.sv
// -----------------------------------------------------------------------------
// pe_cmd_sched
// Round-robin scheduler for the single serial command line that feeds every
// pctrl processing-element node. One requester is granted at a time. Its
// command is sent on tx as one frame, one bit per clock:
//   start bit (0), node address (8b), opcode byte (8b), data window, guard.
// The line is held idle-high until the addressed node's execute window has
// closed.
//
// Ports
//   clk          system clock
//   nRst         asynchronous active-low reset
//   req_valid    [NREQ]     per-requester command pending, held until acked
//   req_addr     [8*NREQ]   node address, requester i at [8i+7:8i]
//   req_op       [3*NREQ]   opcode, requester i at [3i+2:3i]
//   req_data     [32*NREQ]  payload, requester i at [32i+31:32i]
//   req_ack      [NREQ]     one-cycle pulse once the command has been latched
//   tx           serial command line, idles high
//   busy         high from START through the last GUARD cycle
//   frame_done   one-cycle pulse on the last GUARD cycle
// -----------------------------------------------------------------------------
module pe_cmd_sched #(
    parameter int NREQ      = 4,
    parameter int DLEN      = 32,
    parameter int RLEN      = 128,
    parameter int GUARD_CYC = 4
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_addr,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ack,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int AW = 8;
    localparam int OW = 3;
    localparam int DW = 32;
    localparam int PW = $clog2(NREQ);

    // The bit counter has to reach the longest phase minus one.
    localparam int WMAX0 = (RLEN > DLEN) ? RLEN : DLEN;
    localparam int WMAX1 = (WMAX0 > GUARD_CYC) ? WMAX0 : GUARD_CYC;
    localparam int WMAX  = (WMAX1 > AW) ? WMAX1 : AW;
    localparam int CW    = $clog2(WMAX);

    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   NREQ_W   = (PW + 1)'(NREQ);

    localparam logic [OW-1:0] OP_OUT_RES = 3'h2;
    localparam logic [OW-1:0] OP_NO_OP   = 3'h7;

    localparam logic [CW-1:0] CNT_BYTE  = CW'(AW - 1);
    localparam logic [CW-1:0] CNT_DATA  = CW'(DLEN - 1);
    localparam logic [CW-1:0] CNT_RES   = CW'(RLEN - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic          GUARD_ONE = (GUARD_CYC == 1) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_OPC   = 3'd3,
        ST_DATA  = 3'd4,
        ST_GUARD = 3'd5
    } state_t;

    state_t             state_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [PW-1:0]      rr_ptr_d;
    logic [CW-1:0]      cnt_q;
    logic [AW-1:0]      addr_sh_q;
    logic [AW-1:0]      opc_sh_q;
    logic [DW-1:0]      data_sh_q;
    logic               res_q;
    logic [NREQ-1:0]    ack_q;
    logic               tx_q;
    logic               busy_q;
    logic               done_q;

    // Arbitration results for the current IDLE cycle.
    logic [2*NREQ-1:0]  dbl_s;
    logic [NREQ-1:0]    rot_s;
    logic [PW-1:0]      off_s;
    logic [PW:0]        sum_s;
    logic [PW:0]        diff_s;
    logic               win_valid_s;
    logic [PW-1:0]      win_idx_s;
    logic [NREQ-1:0]    win_onehot_s;
    logic [AW-1:0]      sel_addr_s;
    logic [OW-1:0]      sel_op_s;
    logic [DW-1:0]      sel_data_s;

    // Rotate the request vector so that rr_ptr sits at bit 0, then take the
    // lowest set bit; the winner is that offset added back to rr_ptr mod NREQ.
    always_comb begin
        dbl_s       = {req_valid, req_valid} >> rr_ptr_q;
        rot_s       = dbl_s[NREQ-1:0];
        off_s       = '0;
        win_valid_s = 1'b0;
        // Scan from the top so the lowest offset is written last and wins.
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot_s[j]) begin
                off_s       = PW'(j);
                win_valid_s = 1'b1;
            end else begin
                off_s       = off_s;
                win_valid_s = win_valid_s;
            end
        end
        sum_s  = {1'b0, rr_ptr_q} + {1'b0, off_s};
        diff_s = sum_s - NREQ_W;
        if (sum_s >= NREQ_W) begin
            win_idx_s = diff_s[PW-1:0];
        end else begin
            win_idx_s = sum_s[PW-1:0];
        end
        if (win_idx_s == PTR_LAST) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = win_idx_s + PTR_ONE;
        end
    end

    // Select the winning requester's command fields and build its ack vector.
    always_comb begin
        sel_addr_s   = '0;
        sel_op_s     = '0;
        sel_data_s   = '0;
        win_onehot_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_s == PW'(i)) begin
                sel_addr_s      = req_addr[i*AW +: AW];
                sel_op_s        = req_op[i*OW +: OW];
                sel_data_s      = req_data[i*DW +: DW];
                win_onehot_s[i] = 1'b1;
            end else begin
                win_onehot_s[i] = 1'b0;
            end
        end
    end

    // Frame FSM. Outputs are registered from the next state so that tx, busy,
    // req_ack and frame_done all line up with the phase they belong to.
    // Shift registers are refilled with ones so the line idles high once a
    // field has been sent (this also covers DLEN > 32).
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            addr_sh_q <= '0;
            opc_sh_q  <= '0;
            data_sh_q <= '0;
            res_q     <= 1'b0;
            ack_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (win_valid_s) begin
                        ack_q     <= win_onehot_s;
                        rr_ptr_q  <= rr_ptr_d;
                        addr_sh_q <= sel_addr_s;
                        opc_sh_q  <= {4'b0000, sel_op_s, 1'b0};
                        // The readout window keeps the line high, so its
                        // payload is replaced by ones.
                        data_sh_q <= (sel_op_s == OP_OUT_RES) ? {DW{1'b1}} : sel_data_s;
                        res_q     <= (sel_op_s == OP_OUT_RES);
                        if (sel_op_s != OP_NO_OP) begin
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        ack_q <= '0;
                    end
                end
                ST_START: begin
                    ack_q     <= '0;
                    state_q   <= ST_ADDR;
                    cnt_q     <= CNT_BYTE;
                    tx_q      <= addr_sh_q[0];
                    addr_sh_q <= {1'b1, addr_sh_q[AW-1:1]};
                end
                ST_ADDR: begin
                    ack_q <= '0;
                    if (cnt_q == CNT_ZERO) begin
                        state_q  <= ST_OPC;
                        cnt_q    <= CNT_BYTE;
                        tx_q     <= opc_sh_q[0];
                        opc_sh_q <= {1'b1, opc_sh_q[AW-1:1]};
                    end else begin
                        cnt_q     <= cnt_q - CNT_ONE;
                        tx_q      <= addr_sh_q[0];
                        addr_sh_q <= {1'b1, addr_sh_q[AW-1:1]};
                    end
                end
                ST_OPC: begin
                    ack_q <= '0;
                    if (cnt_q == CNT_ZERO) begin
                        state_q   <= ST_DATA;
                        cnt_q     <= res_q ? CNT_RES : CNT_DATA;
                        tx_q      <= data_sh_q[0];
                        data_sh_q <= {1'b1, data_sh_q[DW-1:1]};
                    end else begin
                        cnt_q    <= cnt_q - CNT_ONE;
                        tx_q     <= opc_sh_q[0];
                        opc_sh_q <= {1'b1, opc_sh_q[AW-1:1]};
                    end
                end
                ST_DATA: begin
                    ack_q <= '0;
                    if (cnt_q == CNT_ZERO) begin
                        state_q <= ST_GUARD;
                        cnt_q   <= CNT_GUARD;
                        tx_q    <= 1'b1;
                        done_q  <= GUARD_ONE;
                    end else begin
                        cnt_q     <= cnt_q - CNT_ONE;
                        tx_q      <= data_sh_q[0];
                        data_sh_q <= {1'b1, data_sh_q[DW-1:1]};
                    end
                end
                ST_GUARD: begin
                    ack_q <= '0;
                    tx_q  <= 1'b1;
                    if (cnt_q == CNT_ZERO) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - CNT_ONE;
                        // Flag the cycle in which the counter will read zero.
                        done_q <= (cnt_q == CNT_ONE);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ack    = ack_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pe_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_pe_cmd_sched
// Directed bench for pe_cmd_sched with the default parameters. Inputs change
// and outputs are sampled on the falling clock edge; the DUT acts on the
// rising edge.
// -----------------------------------------------------------------------------
module tb_pe_cmd_sched;

    localparam int NREQ      = 4;
    localparam int DLEN      = 32;
    localparam int RLEN      = 128;
    localparam int GUARD_CYC = 4;

    localparam logic [2:0] OP_OUT_DATA1 = 3'h0;
    localparam logic [2:0] OP_OUT_RES   = 3'h2;
    localparam logic [2:0] OP_LOAD      = 3'h3;
    localparam logic [2:0] OP_MUL       = 3'h5;
    localparam logic [2:0] OP_MUL_ADD   = 3'h6;
    localparam logic [2:0] OP_NO_OP     = 3'h7;

    logic                 clk;
    logic                 nRst;
    logic [NREQ-1:0]      req_valid;
    logic [8*NREQ-1:0]    req_addr;
    logic [3*NREQ-1:0]    req_op;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ack;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    int n_vec;
    int n_err;

    pe_cmd_sched #(
        .NREQ      (NREQ),
        .DLEN      (DLEN),
        .RLEN      (RLEN),
        .GUARD_CYC (GUARD_CYC)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [7:0] a, input logic [2:0] op,
                           input logic [31:0] d);
        req_addr[i*8 +: 8]   = a;
        req_op[i*3 +: 3]     = op;
        req_data[i*32 +: 32] = d;
        req_valid[i]         = 1'b1;
    endtask

    // Expected tx sequence of a frame, bit 0 = START cycle; ones beyond the end.
    function automatic logic [255:0] exp_frame(input logic [7:0] a, input logic [2:0] op,
                                               input logic [31:0] d);
        logic [255:0] f;
        logic [7:0]   ob;
        f    = '1;
        f[0] = 1'b0;
        ob   = {4'b0000, op, 1'b0};
        for (int i = 0; i < 8; i++) begin
            f[1+i] = a[i];
            f[9+i] = ob[i];
        end
        if (op != OP_OUT_RES) begin
            for (int i = 0; i < DLEN; i++) f[17+i] = (i < 32) ? d[i] : 1'b1;
        end
        return f;
    endfunction

    function automatic int exp_len(input logic [2:0] op);
        return 17 + ((op == OP_OUT_RES) ? RLEN : DLEN) + GUARD_CYC;
    endfunction

    task automatic do_reset();
        nRst      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_op    = '0;
        req_data  = '0;
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
    endtask

    // Step falling edges until an ack shows up or the budget runs out.
    task automatic wait_ack(input int bound, output logic [NREQ-1:0] av, output int steps);
        av    = '0;
        steps = 0;
        while (steps < bound) begin
            @(negedge clk);
            steps++;
            if (req_ack != '0) begin
                av = req_ack;
                break;
            end
        end
    endtask

    // Record a frame starting in the current (START) cycle until busy drops.
    task automatic observe_frame(output logic [255:0] rec, output int blen,
                                 output int done_idx, output int done_cnt,
                                 output int extra_acks);
        rec        = '1;
        blen       = 0;
        done_idx   = -1;
        done_cnt   = 0;
        extra_acks = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            if (i < 256) rec[i] = tx;
            blen++;
            if (frame_done) begin
                done_cnt++;
                done_idx = i;
            end
            if (i > 0 && req_ack != '0) extra_acks++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        nRst      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_op    = '0;
        req_data  = '0;
        @(negedge clk);
        n_vec++;
        if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++;
        if (req_ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", req_ack); end
        n_vec++;
        if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", frame_done); end
        nRst = 1'b1;
    endtask

    task automatic test_reset_mid_data();
        logic [NREQ-1:0] av;
        int              st;
        do_reset();
        set_req(0, 8'h5A, OP_LOAD, 32'h0000_0000);
        wait_ack(4, av, st);
        req_valid = '0;
        // Now in T+1; move to T+20 (data bit 2).
        for (int k = 0; k < 19; k++) @(negedge clk);
        n_vec++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL mid_pre: got tx=%b busy=%b want tx=0 busy=1", tx, busy);
        end
        nRst = 1'b0;
        #1;
        n_vec++;
        if (tx !== 1'b1) begin n_err++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_vec++;
        if (req_ack !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ack: got %b want 0000", req_ack); end
        @(negedge clk);
        nRst = 1'b1;
        // Had rr_ptr survived (it was 1), req1 would win here.
        set_req(0, 8'h11, OP_LOAD, 32'h1);
        set_req(1, 8'h22, OP_LOAD, 32'h2);
        wait_ack(4, av, st);
        n_vec++;
        if (av !== 4'b0001 || st != 1) begin
            n_err++; $display("FAIL mid_regrant: got ack=%b after %0d want 0001 after 1", av, st);
        end
        req_valid = '0;
    endtask

    task automatic test_single_load();
        logic [NREQ-1:0] av;
        logic [255:0]    rec;
        logic [255:0]    exp_tx;
        int st, bl, di, dc, xa;
        do_reset();
        set_req(0, 8'hA5, OP_LOAD, 32'h0000_00F1);
        wait_ack(4, av, st);
        req_valid = '0;
        n_vec++;
        if (av !== 4'b0001 || st != 1) begin
            n_err++; $display("FAIL load_ack: got ack=%b after %0d want 0001 after 1", av, st);
        end
        observe_frame(rec, bl, di, dc, xa);
        // Hand-built: start, A5 LSB first, 0x06 LSB first, F1 then zeros, guard ones.
        exp_tx = '1;
        exp_tx[52:0] = {4'b1111, 24'h000000, 8'hF1, 8'h06, 8'hA5, 1'b0};
        n_vec++;
        if (rec !== exp_tx) begin n_err++; $display("FAIL load_tx: got %h want %h", rec, exp_tx); end
        n_vec++;
        if (bl != 53) begin n_err++; $display("FAIL load_busy_len: got %0d want 53", bl); end
        n_vec++;
        if (di != 52 || dc != 1) begin
            n_err++; $display("FAIL load_done: got idx=%0d cnt=%0d want idx=52 cnt=1", di, dc);
        end
        n_vec++;
        if (xa != 0) begin n_err++; $display("FAIL load_extra_ack: got %0d want 0", xa); end
    endtask

    task automatic test_out_res();
        logic [NREQ-1:0] av;
        logic [255:0]    rec;
        logic [255:0]    exp_tx;
        int st, bl, di, dc, xa;
        do_reset();
        set_req(0, 8'h01, OP_OUT_RES, 32'h1234_5678);
        wait_ack(4, av, st);
        req_valid = '0;
        n_vec++;
        if (av !== 4'b0001) begin n_err++; $display("FAIL res_ack: got %b want 0001", av); end
        observe_frame(rec, bl, di, dc, xa);
        exp_tx = '1;
        exp_tx[16:0] = {8'h04, 8'h01, 1'b0};
        n_vec++;
        if (rec !== exp_tx) begin n_err++; $display("FAIL res_tx: got %h want %h", rec, exp_tx); end
        n_vec++;
        if (bl != 149) begin n_err++; $display("FAIL res_busy_len: got %0d want 149", bl); end
        n_vec++;
        if (di != 148 || dc != 1) begin
            n_err++; $display("FAIL res_done: got idx=%0d cnt=%0d want idx=148 cnt=1", di, dc);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] av;
        logic [255:0]    rec;
        logic [7:0]      ad [NREQ];
        logic [2:0]      op [NREQ];
        logic [31:0]     dt [NREQ];
        int st, bl, di, dc, xa, w;
        int order [5] = '{0, 1, 2, 3, 0};
        ad = '{8'h10, 8'h21, 8'h32, 8'h43};
        op = '{OP_LOAD, OP_MUL, OP_MUL_ADD, OP_OUT_DATA1};
        dt = '{32'hDEAD_BEEF, 32'h8000_0001, 32'h0F0F_00FF, 32'h1357_9BDF};
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, ad[i], op[i], dt[i]);
        for (int k = 0; k < 5; k++) begin
            w = order[k];
            wait_ack(4, av, st);
            if (k == 4) req_valid = '0;
            n_vec++;
            if (av !== (4'b0001 << w) || st != 1) begin
                n_err++; $display("FAIL rr_ack%0d: got ack=%b after %0d want %b after 1",
                                  k, av, st, 4'b0001 << w);
            end
            observe_frame(rec, bl, di, dc, xa);
            n_vec++;
            if (rec !== exp_frame(ad[w], op[w], dt[w])) begin
                n_err++; $display("FAIL rr_tx%0d: got %h want %h", k, rec, exp_frame(ad[w], op[w], dt[w]));
            end
            n_vec++;
            if (bl != exp_len(op[w]) || dc != 1 || xa != 0) begin
                n_err++; $display("FAIL rr_frame%0d: got len=%0d done=%0d xacks=%0d want len=%0d done=1 xacks=0",
                                  k, bl, dc, xa, exp_len(op[w]));
            end
        end
    endtask

    task automatic test_no_op();
        logic [NREQ-1:0] av;
        logic [255:0]    rec;
        logic [7:0]      ob;
        int st, bl, di, dc, xa;
        do_reset();
        // Bring rr_ptr to 2 with a NO_OP from requester 1.
        set_req(1, 8'h00, OP_NO_OP, 32'h0);
        wait_ack(4, av, st);
        req_valid = '0;
        n_vec++;
        if (av !== 4'b0010 || tx !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL noop_pre: got ack=%b tx=%b busy=%b want 0010 1 0", av, tx, busy);
        end
        set_req(2, 8'hEE, OP_NO_OP, 32'hFFFF_FFFF);
        set_req(3, 8'h3C, OP_MUL, 32'h0000_0081);
        wait_ack(4, av, st);
        req_valid[2] = 1'b0;
        n_vec++;
        if (av !== 4'b0100 || st != 1 || tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_err++; $display("FAIL noop_ack2: got ack=%b st=%0d tx=%b busy=%b done=%b want 0100 1 1 0 0",
                              av, st, tx, busy, frame_done);
        end
        wait_ack(4, av, st);
        req_valid = '0;
        n_vec++;
        if (av !== 4'b1000 || st != 1 || busy !== 1'b1) begin
            n_err++; $display("FAIL noop_ack3: got ack=%b st=%0d busy=%b want 1000 1 1", av, st, busy);
        end
        observe_frame(rec, bl, di, dc, xa);
        for (int i = 0; i < 8; i++) ob[i] = rec[9+i];
        n_vec++;
        if (ob !== 8'h0A) begin n_err++; $display("FAIL noop_opbyte: got %h want 0a", ob); end
        n_vec++;
        if (rec !== exp_frame(8'h3C, OP_MUL, 32'h0000_0081) || bl != 53) begin
            n_err++; $display("FAIL noop_mul_frame: got %h len=%0d want %h len=53",
                              rec, bl, exp_frame(8'h3C, OP_MUL, 32'h0000_0081));
        end
    endtask

    task automatic test_drop_valid();
        logic [NREQ-1:0] av;
        int st, acks;
        do_reset();
        set_req(0, 8'h0A, OP_LOAD, 32'h5);
        set_req(1, 8'h0B, OP_LOAD, 32'h6);
        wait_ack(4, av, st);
        req_valid[0] = 1'b0;
        n_vec++;
        if (av !== 4'b0001) begin n_err++; $display("FAIL drop_ack0: got %b want 0001", av); end
        acks = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (k == 5) req_valid[1] = 1'b0;
            if (req_ack != '0) acks++;
        end
        n_vec++;
        if (acks != 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL drop_no_ack: got acks=%0d busy=%b want acks=0 busy=0", acks, busy);
        end
        set_req(1, 8'h0C, OP_LOAD, 32'h7);
        set_req(2, 8'h0D, OP_LOAD, 32'h8);
        wait_ack(4, av, st);
        req_valid = '0;
        n_vec++;
        if (av !== 4'b0010) begin n_err++; $display("FAIL drop_rr_next: got %b want 0010", av); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_reset_mid_data();
        test_single_load();
        test_out_res();
        test_round_robin();
        test_no_op();
        test_drop_valid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
